ac_motor_pwm_gate: RTL and testbench
====================================

// Module: ac_motor_pwm_gate
// PURPOSE
//  Three-phase sine-triangle comparator with dead-time insertion, downstream of AC_MOTOR_SINE/AC_MOTOR_TRIANGLE.
//  Per phase: compares sineN to triangle and drives complementary high/low gate signals for one inverter leg.
//  Dead time and fault blanking ensure high and low are never asserted together.
// PARAMETERS
//  WIDTH     12  signed sample width of sine and triangle inputs
//  DEADTIME  25  dead-time length in clk cycles (>=1); both gates of a leg low for this long
//  DT_BITS    8  width of the per-phase dead-time counter; DEADTIME < 2**DT_BITS
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous reset, active low
//  enable     in   1      1 = modulate; 0 = all gates off, clears fault latch
//  fault      in   1      synchronous, active high; forces all gates off and sets fault_latched
//  triangle   in   WIDTH  signed carrier from AC_MOTOR_TRIANGLE
//  tri_valley in   1      one-cycle strobe at carrier minimum (shadow load point)
//  sine1..3   in   WIDTH  signed references from AC_MOTOR_SINE
//  gate_hi    out  3      high-side gates, bit N-1 = phase N
//  gate_lo    out  3      low-side gates
//  fault_latched out 1    sticky fault flag
// BEHAVIOUR
//  Reset: gate_hi=0, gate_lo=0, fault_latched=0, all phase FSMs OFF, counters 0, shadow refs 0.
//  Compare is signed: demand_N = (ref_N > triangle); equality -> demand 0 (low side).
//  demand_N is registered (demand_q); gates are registered decodes of FSM state.
//  Per-phase FSM states: OFF, HI, LO, DT (both low, counter running).
//   OFF -> DT (counter=0) when enable=1 and fault_latched=0
//   HI  -> DT when demand_q=0;  LO -> DT when demand_q=1
//   DT: counter increments each cycle; when counter reaches DEADTIME-1, next state is HI if demand_q=1, else LO
//   Reversal during DT does not shorten or restart it; DT always completes, then follows current demand_q
//  Latency: input crossing sampled at edge k -> demand_q at k+1 -> active gate drops at k+2 -> opposite gate rises
//   at k+2+DEADTIME.
//  Override priority: reset_n > fault/fault_latched > enable=0 > FSM.
//   Either override forces every phase to OFF on the next edge, with both gates low.
//   No dead time is required on the way into OFF.
//  fault=1 sets fault_latched on the next edge; it holds until enable=0 with fault=0, then clears.
//  Restart from OFF always passes through DT first, so the first gate asserts DEADTIME cycles after enable.
//  Invariant: gate_hi[N] & gate_lo[N] == 0 in every cycle, including during reset release and overrides.
//  Mid-operation reset: gates low asynchronously, with no dependence on clk.
// CONFIGURATION
//  AC_MOTOR_PWM_SHADOW_EN defined:
//   ref_N is loaded from sineN only on cycles with tri_valley=1 (glitch-free, one update per carrier period).
//   Shadow registers reset to 0.
//  Not defined: ref_N = sineN directly; tri_valley is ignored.
// STRUCTURE
//  Package ac_motor_pkg: WIDTH default, state encoding localparams (OFF/HI/LO/DT), and DEADTIME default.
//  Sub-module ac_motor_pwm_leg: one FSM, dead-time counter, and gate register pair; instantiated three times.
//  The top level holds the comparators, shadow registers, and fault latch.
// TESTING
//  1. Reset and enable: hold reset_n=0 -> all gates 0. Release, enable=1 with sine1=500, triangle=0
//     -> gate_hi[0] rises exactly DEADTIME+1 cycles after enable is sampled; gate_lo[0] stays 0.
//  2. Crossing: sine1=0, triangle ramps -2047..2047 step 1/clk -> gate_hi[0] falls 2 cycles after triangle
//     passes 0; gate_lo[0] rises 25 cycles later.
//  3. Reversal in DT: toggle the demand back after 5 DT cycles -> both gates stay low the full 25 cycles,
//     then the original side re-asserts.
//  4. Fault: fault=1 for 1 cycle mid-run -> all gates 0 next edge, fault_latched=1 persists.
//     Then enable=0 for 1 cycle -> flag clears; re-enable -> DT then modulation.
//  5. Shadow (macro on): change sine2 between valleys -> the compare uses the old value until tri_valley,
//     then switches. With the macro off, the switch is immediate.
//  6. Full run, frequency=10 through sine and triangle for 25000 cycles -> assert that no cycle has
//     hi&lo=1 on any phase and that every transition contains >=DEADTIME low-low cycles.

Source files
------------

// File: rtl/ac_motor_pkg.sv
// rtl/ac_motor_pkg.sv - shared defaults and leg state encoding for the three-phase PWM gate driver
package ac_motor_pkg;

    localparam int WIDTH_DEFAULT    = 12;
    localparam int DEADTIME_DEFAULT = 25;
    localparam int DT_BITS_DEFAULT  = 8;
    localparam int NUM_PHASES       = 3;

    // One inverter leg: idle, high side on, low side on, or both off while dead time runs
    typedef enum logic [1:0] {
        LEG_OFF = 2'd0,
        LEG_HI  = 2'd1,
        LEG_LO  = 2'd2,
        LEG_DT  = 2'd3
    } leg_state_e;

endpackage

// File: rtl/ac_motor_pwm_leg.sv
// rtl/ac_motor_pwm_leg.sv - one inverter leg: state machine, dead-time counter and registered gate pair
module ac_motor_pwm_leg
    import ac_motor_pkg::*;
#(
    parameter int DEADTIME = DEADTIME_DEFAULT,
    parameter int DT_BITS  = DT_BITS_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic override,
    input  logic demand,
    output logic gate_hi,
    output logic gate_lo
);

    localparam logic [DT_BITS-1:0] DT_LAST = DT_BITS'(DEADTIME - 1);

    leg_state_e         state_q, state_d;
    logic [DT_BITS-1:0] cnt_q, cnt_d;
    logic               gate_hi_q, gate_hi_d;
    logic               gate_lo_q, gate_lo_d;

    // Next state and gate decode; an override drops both gates on the same edge it forces OFF
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gate_hi_d = 1'b0;
        gate_lo_d = 1'b0;
        if (override) begin
            state_d = LEG_OFF;
            cnt_d   = '0;
        end else begin
            gate_hi_d = (state_q == LEG_HI);
            gate_lo_d = (state_q == LEG_LO);
            case (state_q)
                LEG_OFF: begin
                    state_d = LEG_DT;
                    cnt_d   = '0;
                end
                LEG_HI: begin
                    if (!demand) begin
                        state_d = LEG_DT;
                        cnt_d   = '0;
                    end
                end
                LEG_LO: begin
                    if (demand) begin
                        state_d = LEG_DT;
                        cnt_d   = '0;
                    end
                end
                LEG_DT: begin
                    // Dead time always runs to completion; the side chosen is whatever demand says at the end
                    if (cnt_q == DT_LAST) begin
                        state_d = demand ? LEG_HI : LEG_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = LEG_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and gate registers; reset clears gates without waiting for a clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= LEG_OFF;
            cnt_q     <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_hi_q <= gate_hi_d;
            gate_lo_q <= gate_lo_d;
        end
    end

    assign gate_hi = gate_hi_q;
    assign gate_lo = gate_lo_q;

endmodule

// File: rtl/ac_motor_pwm_gate.sv
// rtl/ac_motor_pwm_gate.sv - three-phase sine-triangle comparator with dead time; AC_MOTOR_PWM_SHADOW_EN enables valley-loaded shadow references
module ac_motor_pwm_gate
    import ac_motor_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEFAULT,
    parameter int DEADTIME = DEADTIME_DEFAULT,
    parameter int DT_BITS  = DT_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    fault,
    input  logic signed [WIDTH-1:0] triangle,
    input  logic                    tri_valley,
    input  logic signed [WIDTH-1:0] sine1,
    input  logic signed [WIDTH-1:0] sine2,
    input  logic signed [WIDTH-1:0] sine3,
    output logic [NUM_PHASES-1:0]   gate_hi,
    output logic [NUM_PHASES-1:0]   gate_lo,
    output logic                    fault_latched
);

    logic signed [WIDTH-1:0] sine_in [NUM_PHASES];
    logic signed [WIDTH-1:0] ref_val [NUM_PHASES];
    logic [NUM_PHASES-1:0]   demand_d, demand_q;
    logic                    fault_latched_d, fault_latched_q;
    logic                    override;

    assign sine_in[0] = sine1;
    assign sine_in[1] = sine2;
    assign sine_in[2] = sine3;

`ifdef AC_MOTOR_PWM_SHADOW_EN
    logic signed [WIDTH-1:0] ref_d [NUM_PHASES];
    logic signed [WIDTH-1:0] ref_q [NUM_PHASES];

    // References change only at the carrier valley so each period compares against one value
    always_comb begin
        ref_d = ref_q;
        if (tri_valley) begin
            ref_d = sine_in;
        end
    end

    // Shadow reference registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_q <= '{default: '0};
        end else begin
            ref_q <= ref_d;
        end
    end

    assign ref_val = ref_q;
`else
    logic valley_unused;
    assign valley_unused = tri_valley;
    assign ref_val       = sine_in;
`endif

    // Signed compare; a tie selects the low side
    always_comb begin
        demand_d = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            demand_d[i] = (ref_val[i] > triangle);
        end
    end

    // Sticky fault flag: set by fault, cleared only by enable low while fault is low
    always_comb begin
        fault_latched_d = fault_latched_q;
        if (fault) begin
            fault_latched_d = 1'b1;
        end else if (!enable) begin
            fault_latched_d = 1'b0;
        end
    end

    assign override = fault | fault_latched_q | ~enable;

    // Demand and fault flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            demand_q        <= '0;
            fault_latched_q <= 1'b0;
        end else begin
            demand_q        <= demand_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    assign fault_latched = fault_latched_q;

    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_leg
        ac_motor_pwm_leg #(
            .DEADTIME (DEADTIME),
            .DT_BITS  (DT_BITS)
        ) u_leg (
            .clk      (clk),
            .reset_n  (reset_n),
            .override (override),
            .demand   (demand_q[g]),
            .gate_hi  (gate_hi[g]),
            .gate_lo  (gate_lo[g])
        );
    end

endmodule

// File: tb/tb_ac_motor_pwm_gate.sv
// tb/tb_ac_motor_pwm_gate.sv - self-checking bench for ac_motor_pwm_gate with a timestamp-based reference model
module tb_ac_motor_pwm_gate;

    localparam int W = 12;
    localparam int D = 25;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable = 1'b0;
    logic                fault = 1'b0;
    logic signed [W-1:0] triangle = '0;
    logic                tri_valley = 1'b0;
    logic signed [W-1:0] sine1 = '0;
    logic signed [W-1:0] sine2 = '0;
    logic signed [W-1:0] sine3 = '0;
    logic [2:0]          gate_hi;
    logic [2:0]          gate_lo;
    logic                fault_latched;

    int vectors = 0;
    int miscompares = 0;

    ac_motor_pwm_gate #(
        .WIDTH    (W),
        .DEADTIME (D),
        .DT_BITS  (8)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .fault         (fault),
        .triangle      (triangle),
        .tri_valley    (tri_valley),
        .sine1         (sine1),
        .sine2         (sine2),
        .sine3         (sine3),
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    function automatic logic signed [W-1:0] sine_of(input int p);
        case (p)
            0:       return sine1;
            1:       return sine2;
            default: return sine3;
        endcase
    endfunction

    // Reference model: each leg is off, driving one side, or dead until an absolute edge number
    localparam int M_OFF = 0, M_DRIVE = 1, M_DEAD = 2;
    int                  m_cycle;
    int                  m_mode  [3];
    bit                  m_hi    [3];
    int                  m_until [3];
    bit                  m_dem   [3];
    logic signed [W-1:0] m_ref   [3];
    bit                  m_latch;
    bit                  m_ovr;
    logic [2:0]          exp_hi, exp_lo;
    logic                exp_latch;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_cycle = 0; m_latch = 0; exp_hi = '0; exp_lo = '0; exp_latch = 0;
                for (int p = 0; p < 3; p++) begin
                    m_mode[p] = M_OFF; m_hi[p] = 0; m_until[p] = 0; m_dem[p] = 0; m_ref[p] = '0;
                end
            end else begin
                m_ovr = fault || m_latch || !enable;
                for (int p = 0; p < 3; p++) begin
                    exp_hi[p] = !m_ovr && (m_mode[p] == M_DRIVE) && m_hi[p];
                    exp_lo[p] = !m_ovr && (m_mode[p] == M_DRIVE) && !m_hi[p];
                    if (m_ovr) begin
                        m_mode[p] = M_OFF;
                    end else if (m_mode[p] == M_OFF || (m_mode[p] == M_DRIVE && m_hi[p] != m_dem[p])) begin
                        m_mode[p] = M_DEAD; m_until[p] = m_cycle + D;
                    end else if (m_mode[p] == M_DEAD && m_cycle == m_until[p]) begin
                        m_mode[p] = M_DRIVE; m_hi[p] = m_dem[p];
                    end
                end
                for (int p = 0; p < 3; p++) begin
`ifdef AC_MOTOR_PWM_SHADOW_EN
                    m_dem[p] = (m_ref[p] > triangle);
                    if (tri_valley) m_ref[p] = sine_of(p);
`else
                    m_ref[p] = sine_of(p);
                    m_dem[p] = (m_ref[p] > triangle);
`endif
                end
                m_latch = fault ? 1'b1 : (enable ? m_latch : 1'b0);
                exp_latch = m_latch;
                m_cycle++;
            end
        end
    end

    task automatic setup_refs(input int s1, input int s2, input int s3, input int tv);
        @(negedge clk);
        sine1 = 12'(s1); sine2 = 12'(s2); sine3 = 12'(s3); triangle = 12'(tv); tri_valley = 1'b1;
        @(negedge clk);
        tri_valley = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; fault = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sine1 = 12'($urandom_range(0, 4095)); sine2 = 12'($urandom_range(0, 4095));
            triangle = 12'($urandom_range(0, 4095)); tri_valley = 1'($urandom_range(0, 1));
            fault = (i == 2);
            vectors++; if (gate_hi !== 3'b000) begin miscompares++; $display("FAIL reset_gate_hi: got %b want 000", gate_hi); end
            vectors++; if (gate_lo !== 3'b000) begin miscompares++; $display("FAIL reset_gate_lo: got %b want 000", gate_lo); end
            vectors++; if (fault_latched !== 1'b0) begin miscompares++; $display("FAIL reset_fault_latched: got %b want 0", fault_latched); end
        end
        @(negedge clk);
        enable = 1'b0; fault = 1'b0; tri_valley = 1'b0; reset_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({gate_hi, gate_lo, fault_latched} !== 7'b0) begin
            miscompares++; $display("FAIL after_reset_idle: got %b want 0000000", {gate_hi, gate_lo, fault_latched});
        end
    endtask

    task automatic test_enable();
        int  n;
        bit  lo_seen;
        setup_refs(500, 0, 0, 0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        n = 0; lo_seen = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (gate_lo[0]) lo_seen = 1;
            if (gate_hi[0]) break;
        end
        vectors++; if (n - 1 !== D + 1) begin miscompares++; $display("FAIL enable_latency: got %0d want %0d", n - 1, D + 1); end
        vectors++; if (lo_seen) begin miscompares++; $display("FAIL enable_lo_glitch: got 1 want 0"); end
        vectors++; if (gate_hi !== 3'b001 || gate_lo !== 3'b110) begin
            miscompares++; $display("FAIL enable_gates: got hi=%b lo=%b want hi=001 lo=110", gate_hi, gate_lo);
        end
    endtask

    task automatic test_crossing();
        int fall_e, lo_e;
        setup_refs(0, 0, 0, -2047);
        repeat (D + 5) @(negedge clk);
        fall_e = -1; lo_e = -1;
        for (int i = 0; i < 4095; i++) begin
            if (i > 0) begin
                vectors++;
                if (gate_hi !== exp_hi || gate_lo !== exp_lo) begin
                    miscompares++; $display("FAIL crossing_model: edge %0d got hi=%b lo=%b want hi=%b lo=%b", i - 1, gate_hi, gate_lo, exp_hi, exp_lo);
                end
                if (fall_e < 0 && !gate_hi[0]) fall_e = i - 1;
                if (lo_e < 0 && gate_lo[0]) lo_e = i - 1;
            end
            triangle = 12'(-2047 + i);
            @(negedge clk);
        end
        vectors++; if (fall_e - 2047 !== 2) begin miscompares++; $display("FAIL crossing_hi_fall: got %0d want 2", fall_e - 2047); end
        vectors++; if (lo_e - fall_e !== D) begin miscompares++; $display("FAIL crossing_lo_rise: got %0d want %0d", lo_e - fall_e, D); end
    endtask

    task automatic test_reversal();
        int n, low;
        setup_refs(500, 0, 0, 0);
        repeat (D + 6) @(negedge clk);
        vectors++; if (gate_hi[0] !== 1'b1) begin miscompares++; $display("FAIL reversal_setup: got %b want 1", gate_hi[0]); end
        sine1 = -12'sd500; tri_valley = 1'b1;
        n = 0;
        while (gate_hi[0] && n < 10) begin @(negedge clk); tri_valley = 1'b0; n++; end
        tri_valley = 1'b0;
        vectors++; if (gate_hi[0] !== 1'b0) begin miscompares++; $display("FAIL reversal_fall: got %b want 0", gate_hi[0]); end
        low = 0;
        while (!gate_hi[0] && !gate_lo[0] && low < 100) begin
            low++;
            if (low == 5) begin sine1 = 12'sd500; tri_valley = 1'b1; end
            else tri_valley = 1'b0;
            @(negedge clk);
        end
        tri_valley = 1'b0;
        vectors++; if (low !== D) begin miscompares++; $display("FAIL reversal_dead_len: got %0d want %0d", low, D); end
        vectors++; if (gate_hi[0] !== 1'b1 || gate_lo[0] !== 1'b0) begin
            miscompares++; $display("FAIL reversal_side: got hi=%b lo=%b want hi=1 lo=0", gate_hi[0], gate_lo[0]);
        end
    endtask

    task automatic test_fault();
        int n;
        setup_refs(500, -500, 500, 0);
        repeat (D + 6) @(negedge clk);
        vectors++; if (gate_hi !== 3'b101 || gate_lo !== 3'b010) begin
            miscompares++; $display("FAIL fault_setup: got hi=%b lo=%b want hi=101 lo=010", gate_hi, gate_lo);
        end
        fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        vectors++; if ({gate_hi, gate_lo, fault_latched} !== 7'b0000001) begin
            miscompares++; $display("FAIL fault_immediate: got %b want 0000001", {gate_hi, gate_lo, fault_latched});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if ({gate_hi, gate_lo, fault_latched} !== 7'b0000001) begin
                miscompares++; $display("FAIL fault_hold: got %b want 0000001", {gate_hi, gate_lo, fault_latched});
            end
        end
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        vectors++; if ({gate_hi, gate_lo, fault_latched} !== 7'b0) begin
            miscompares++; $display("FAIL fault_clear: got %b want 0000000", {gate_hi, gate_lo, fault_latched});
        end
        n = 0;
        while (!gate_hi[0] && n < 100) begin @(negedge clk); n++; end
        vectors++; if (n - 1 !== D + 1) begin miscompares++; $display("FAIL fault_restart_latency: got %0d want %0d", n - 1, D + 1); end
        vectors++; if (gate_hi !== 3'b101 || gate_lo !== 3'b010) begin
            miscompares++; $display("FAIL fault_restart_gates: got hi=%b lo=%b want hi=101 lo=010", gate_hi, gate_lo);
        end
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++; if ({gate_hi, gate_lo, fault_latched} !== 7'b0) begin
            miscompares++; $display("FAIL async_reset: got %b want 0000000", {gate_hi, gate_lo, fault_latched});
        end
        @(negedge clk);
        reset_n = 1'b1; tri_valley = 1'b1;
        n = 0;
        while ((gate_hi | gate_lo) == 3'b000 && n < 100) begin @(negedge clk); tri_valley = 1'b0; n++; end
        tri_valley = 1'b0;
        vectors++; if (n - 1 !== D + 1) begin miscompares++; $display("FAIL reset_restart_latency: got %0d want %0d", n - 1, D + 1); end
        vectors++; if (gate_hi !== 3'b101 || gate_lo !== 3'b010) begin
            miscompares++; $display("FAIL reset_restart_gates: got hi=%b lo=%b want hi=101 lo=010", gate_hi, gate_lo);
        end
    endtask

    task automatic test_shadow();
        int n;
        setup_refs(500, 500, 500, 0);
        repeat (D + 6) @(negedge clk);
        vectors++; if (gate_hi !== 3'b111) begin miscompares++; $display("FAIL shadow_setup: got %b want 111", gate_hi); end
        sine2 = -12'sd500;
        n = 0;
`ifdef AC_MOTOR_PWM_SHADOW_EN
        while (gate_hi[1] && n < 40) begin @(negedge clk); n++; end
        vectors++; if (gate_hi[1] !== 1'b1) begin miscompares++; $display("FAIL shadow_hold: got %b want 1", gate_hi[1]); end
        tri_valley = 1'b1;
        n = 0;
        while (gate_hi[1] && n < 20) begin @(negedge clk); tri_valley = 1'b0; n++; end
        tri_valley = 1'b0;
        vectors++; if (n - 1 !== 3) begin miscompares++; $display("FAIL shadow_switch_latency: got %0d want 3", n - 1); end
`else
        while (gate_hi[1] && n < 20) begin @(negedge clk); n++; end
        vectors++; if (n - 1 !== 2) begin miscompares++; $display("FAIL direct_switch_latency: got %0d want 2", n - 1); end
`endif
    endtask

    function automatic int wave(input int x);
        int xm;
        xm = x % 2500;
        if (xm < 1250) return -1800 + (xm * 3600) / 1250;
        return 1800 - ((xm - 1250) * 3600) / 1250;
    endfunction

    task automatic test_full_run();
        int low_run [3];
        int c, up;
        enable = 1'b0; fault = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 3; p++) low_run[p] = 0;
        for (int it = 0; it < 25000; it++) begin
            vectors++;
            if (gate_hi !== exp_hi || gate_lo !== exp_lo || fault_latched !== exp_latch) begin
                miscompares++;
                $display("FAIL run_model: cycle %0d got hi=%b lo=%b fl=%b want hi=%b lo=%b fl=%b",
                         it, gate_hi, gate_lo, fault_latched, exp_hi, exp_lo, exp_latch);
            end
            vectors++;
            if ((gate_hi & gate_lo) !== 3'b000) begin
                miscompares++; $display("FAIL run_overlap: cycle %0d got %b want 000", it, gate_hi & gate_lo);
            end
            for (int p = 0; p < 3; p++) begin
                if (!gate_hi[p] && !gate_lo[p]) begin
                    low_run[p]++;
                end else begin
                    if (low_run[p] > 0) begin
                        vectors++;
                        if (low_run[p] < D) begin
                            miscompares++; $display("FAIL run_deadtime: phase %0d got %0d want >=%0d", p + 1, low_run[p], D);
                        end
                    end
                    low_run[p] = 0;
                end
            end
            c = it % 128;
            up = (c <= 64) ? c : 128 - c;
            triangle = 12'(-2016 + 63 * up);
            tri_valley = (c == 0);
            sine1 = 12'(wave(it) + int'($urandom_range(0, 40)) - 20);
            sine2 = 12'(wave(it + 833) + int'($urandom_range(0, 40)) - 20);
            sine3 = 12'(wave(it + 1667) + int'($urandom_range(0, 40)) - 20);
            fault = ($urandom_range(0, 2999) == 0);
            enable = ($urandom_range(0, 999) != 0) || (it == 0);
            @(negedge clk);
        end
        fault = 1'b0; tri_valley = 1'b0;
    endtask

    initial begin
        test_reset();
        test_enable();
        test_crossing();
        test_reversal();
        test_fault();
        test_async_reset();
        test_shadow();
        test_full_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
